// File: rtl/regfile_pkg.sv
// Shared constants and clear-engine state encoding for the multi-port register file.
// Decode imports the default widths from here so both sides agree on the architectural sizes.
package regfile_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clr_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Post-reset clear engine: walks every register index once, emitting a zero-write per edge.
// The sweep ends when the index reaches all-ones; the counter is never relied on to wrap.
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              Reset,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   clr_state_e        state_q, state_d;
   logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

   // Next-state: Reset always (re)starts the sweep at index 0
   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      if (Reset) begin
         state_d   = ST_CLEAR;
         clr_idx_d = {ADDR_W{1'b0}};
      end else begin
         case (state_q)
            ST_CLEAR: begin
               clr_idx_d = clr_idx_q + 1'b1;
               if (clr_idx_q == {ADDR_W{1'b1}}) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_CLEAR;
               end
            end
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d   = ST_CLEAR;
               clr_idx_d = {ADDR_W{1'b0}};
            end
         endcase
      end
   end

   // State and index registers
   always_ff @(posedge clk) begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
   end

   assign busy     = (state_q == ST_CLEAR);
   assign clr_we   = (state_q == ST_CLEAR) && !Reset;
   assign clr_addr = clr_idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-first bypass, optional zero register,
// a dedicated PC register and a sequential clear engine that zeroes the array after Reset.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     Reset,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [NUM_RD*ADDR_W-1:0] raddr,
   output logic [NUM_RD*DATA_W-1:0] rdata,
   input  logic                     pc_we,
   input  logic [DATA_W-1:0]        pc_in,
   output logic [DATA_W-1:0]        pc_out,
   output logic                     busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DATA_W-1:0] pc_q, pc_d;

   logic              clr_we_s;
   logic [ADDR_W-1:0] clr_addr_s;
   logic              wr_en_s;
   logic [ADDR_W-1:0] wr_addr_s;
   logic [DATA_W-1:0] wr_data_s;
   logic              wr_zero_hit_s;

   regfile_clear_fsm #(
      .ADDR_W (ADDR_W)
   ) u_clear (
      .clk      (clk),
      .Reset    (Reset),
      .busy     (busy),
      .clr_we   (clr_we_s),
      .clr_addr (clr_addr_s)
   );

   assign wr_zero_hit_s = (ZERO_REG != 0) && (waddr == {ADDR_W{1'b0}});

   // Single array write port: the clear engine owns it while busy, user writes otherwise
   always_comb begin
      wr_en_s   = 1'b0;
      wr_addr_s = {ADDR_W{1'b0}};
      wr_data_s = {DATA_W{1'b0}};
      if (clr_we_s) begin
         wr_en_s   = 1'b1;
         wr_addr_s = clr_addr_s;
         wr_data_s = {DATA_W{1'b0}};
      end else if (we && !busy && !Reset && !wr_zero_hit_s) begin
         wr_en_s   = 1'b1;
         wr_addr_s = waddr;
         wr_data_s = wdata;
      end else begin
         wr_en_s   = 1'b0;
      end
   end

   // Array next-value
   always_comb begin
      mem_d = mem_q;
      if (wr_en_s) begin
         mem_d[wr_addr_s] = wr_data_s;
      end else begin
         mem_d[wr_addr_s] = mem_q[wr_addr_s];
      end
   end

   // PC next-value; Reset dominates a simultaneous load
   always_comb begin
      pc_d = pc_q;
      if (Reset) begin
         pc_d = {DATA_W{1'b0}};
      end else if (pc_we) begin
         pc_d = pc_in;
      end else begin
         pc_d = pc_q;
      end
   end

   // Storage registers; the array has no reset and is zeroed by the clear engine instead
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      pc_q  <= pc_d;
   end

   assign pc_out = pc_q;

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra_s;
      logic [DATA_W-1:0] rd_s;

      assign ra_s = raddr[k*ADDR_W +: ADDR_W];

      // Read priority: busy, zero register, write bypass, array
      always_comb begin
         rd_s = {DATA_W{1'b0}};
         if (busy) begin
            rd_s = {DATA_W{1'b0}};
         end else if ((ZERO_REG != 0) && (ra_s == {ADDR_W{1'b0}})) begin
            rd_s = {DATA_W{1'b0}};
         end else if (we && (waddr == ra_s)) begin
            rd_s = wdata;
         end else begin
            rd_s = mem_q[ra_s];
         end
      end

      assign rdata[k*DATA_W +: DATA_W] = rd_s;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp (4 read ports, zero register on) against a behavioural model
// that tracks the file contents, clear countdown and PC, checked every negative clock edge.
module tb_regfile_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 4;
   localparam int DEPTH = 32;

   logic            clk;
   logic            Reset;
   logic            we;
   logic [AW-1:0]   waddr;
   logic [DW-1:0]   wdata;
   logic [NR*AW-1:0] raddr;
   logic [NR*DW-1:0] rdata;
   logic            pc_we;
   logic [DW-1:0]   pc_in;
   logic [DW-1:0]   pc_out;
   logic            busy;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_mp #(
      .DATA_W   (DW),
      .ADDR_W   (AW),
      .NUM_RD   (NR),
      .ZERO_REG (1)
   ) dut (
      .clk    (clk),
      .Reset  (Reset),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .raddr  (raddr),
      .rdata  (rdata),
      .pc_we  (pc_we),
      .pc_in  (pc_in),
      .pc_out (pc_out),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model
   logic [DW-1:0] m_mem [DEPTH];
   logic [DW-1:0] m_pc;
   int            m_busy_left = 0;
   bit            m_started = 1'b0;

   always @(posedge clk) begin
      if (Reset) begin
         m_busy_left <= DEPTH;
         m_pc        <= 32'h0;
         m_started   <= 1'b1;
      end else begin
         if (pc_we) m_pc <= pc_in;
         if (m_busy_left > 0) begin
            m_busy_left <= m_busy_left - 1;
            if (m_busy_left == 1) begin
               for (int i = 0; i < DEPTH; i++) m_mem[i] <= 32'h0;
            end
         end else if (we && waddr != 5'd0) begin
            m_mem[waddr] <= wdata;
         end
      end
   end

   function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
      if (m_busy_left > 0) return 32'h0;
      if (a == 5'd0) return 32'h0;
      if (we && waddr == a) return wdata;
      return m_mem[a];
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (m_started) begin
         check("busy", {31'h0, busy}, {31'h0, (m_busy_left > 0)});
         check("pc_out", pc_out, m_pc);
         for (int k = 0; k < NR; k++) begin
            check($sformatf("rdata[%0d]", k), rdata[k*DW +: DW], model_read(raddr[k*AW +: AW]));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ra(input int k, input logic [AW-1:0] a);
      raddr[k*AW +: AW] = a;
   endtask

   function automatic logic [DW-1:0] rd(input int k);
      return rdata[k*DW +: DW];
   endfunction

   task automatic wait_clear(input string name);
      repeat (31) tick();
      check({name, "_busy_31"}, {31'h0, busy}, 32'h1);
      tick();
      check({name, "_busy_32"}, {31'h0, busy}, 32'h0);
   endtask

   initial begin
      Reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
      pc_we = 1'b0; pc_in = '0;
      tick();
      Reset = 1'b0;
      #1;
      check("rst_busy", {31'h0, busy}, 32'h1);
      check("rst_pc", pc_out, 32'h0);
      check("rst_rdata", rd(0), 32'h0);
      wait_clear("clear1");

      set_ra(0, 5'd7); set_ra(1, 5'd31); set_ra(2, 5'd1); set_ra(3, 5'd16);
      #1;
      check("post_clear_rd7", rd(0), 32'h0);
      check("post_clear_rd31", rd(1), 32'h0);

      we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; set_ra(0, 5'd5);
      #1;
      check("bypass", rd(0), 32'hDEADBEEF);
      tick();
      we = 1'b0;
      #1;
      check("array_read", rd(0), 32'hDEADBEEF);

      we = 1'b1; waddr = 5'd0; wdata = 32'h00001234; set_ra(0, 5'd0); set_ra(1, 5'd0);
      #1;
      check("zero_bypass0", rd(0), 32'h0);
      check("zero_bypass1", rd(1), 32'h0);
      tick();
      we = 1'b0;
      #1;
      check("zero_after", rd(0), 32'h0);

      pc_we = 1'b1; pc_in = 32'h00400000;
      tick();
      pc_we = 1'b0;
      #1;
      check("pc_load", pc_out, 32'h00400000);

      for (int i = 0; i < NR; i++) begin
         we = 1'b1; waddr = AW'(i + 1); wdata = 32'h11110000 * (i + 1);
         tick();
      end
      we = 1'b0;
      for (int i = 0; i < NR; i++) set_ra(i, AW'(i + 1));
      #1;
      check("port0_own", rd(0), 32'h11110000);
      check("port1_own", rd(1), 32'h22220000);
      check("port2_own", rd(2), 32'h33330000);
      check("port3_own", rd(3), 32'h44440000);
      for (int i = 0; i < NR; i++) set_ra(i, 5'd5);
      #1;
      check("same_addr3", rd(3), 32'hDEADBEEF);

      we = 1'b1; waddr = 5'd31; wdata = 32'hA5A5A5A5;
      tick();
      we = 1'b0; set_ra(0, 5'd31); set_ra(1, 5'd9); set_ra(2, 5'd12); set_ra(3, 5'd5);
      #1;
      check("e31_written", rd(0), 32'hA5A5A5A5);
      pc_we = 1'b1; pc_in = 32'h00400000;
      Reset = 1'b1;
      tick();
      Reset = 1'b0; pc_we = 1'b0;
      repeat (10) tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      we = 1'b1; waddr = 5'd9; wdata = 32'h0000FFFF;
      pc_we = 1'b1; pc_in = 32'h00000020;
      tick();
      we = 1'b0; pc_we = 1'b0;
      check("pc_while_busy", pc_out, 32'h00000020);
      repeat (30) tick();
      check("clear2_busy_31", {31'h0, busy}, 32'h1);
      we = 1'b1; waddr = 5'd12; wdata = 32'hCAFEF00D;
      tick();
      we = 1'b0;
      #1;
      check("clear2_busy_32", {31'h0, busy}, 32'h0);
      check("e31_cleared", rd(0), 32'h0);
      check("busy_write_dropped", rd(1), 32'h0);
      check("fall_write_dropped", rd(2), 32'h0);
      check("e5_cleared", rd(3), 32'h0);

      pc_we = 1'b1; pc_in = 32'h00400000;
      tick();
      check("pc_reload", pc_out, 32'h00400000);
      Reset = 1'b1; pc_in = 32'h00000010;
      tick();
      Reset = 1'b0; pc_we = 1'b0;
      check("rst_beats_pcwe", pc_out, 32'h0);
      wait_clear("clear3");
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
